// File: rtl/tank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tank_pkg
//  Description : Shared constants and types for the per-player tank
//                controller: HID keycodes, indices into the pressed-key
//                vector, facing direction and reload state encodings.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package tank_pkg;

    // HID usage IDs for the keys the tank reacts to
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_R     = 8'h15;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    // Bit positions inside the pressed vector {space, r, s, w, d, a}
    localparam int PB_A     = 0;
    localparam int PB_D     = 1;
    localparam int PB_W     = 2;
    localparam int PB_S     = 3;
    localparam int PB_R     = 4;
    localparam int PB_SPACE = 5;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [0:0] {
        RL_IDLE = 1'b0,
        RL_BUSY = 1'b1
    } rl_state_t;

endpackage : tank_pkg
`default_nettype wire

// File: rtl/tank_key_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tank_key_decode
//  Description : Combinational scan of NKEYS packed HID keycode slots.
//                A key counts as pressed if it appears in any slot; repeated
//                slots collapse to a single press. Empty slots (8'h00) never
//                match any tracked key.
//  Ports       : keycode [8*NKEYS-1:0] in  - packed slots, slot 0 in [7:0]
//                pressed [5:0]         out - {space, r, s, w, d, a}
//  Revision    : 1.0 - initial release
// ============================================================================
module tank_key_decode
    import tank_pkg::*;
#(
    parameter int NKEYS = 6
) (
    input  logic [8*NKEYS-1:0] keycode,
    output logic [5:0]         pressed
);

    always_comb begin
        pressed = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (keycode[8*i +: 8] == KEY_A)     pressed[PB_A]     = 1'b1;
            if (keycode[8*i +: 8] == KEY_D)     pressed[PB_D]     = 1'b1;
            if (keycode[8*i +: 8] == KEY_W)     pressed[PB_W]     = 1'b1;
            if (keycode[8*i +: 8] == KEY_S)     pressed[PB_S]     = 1'b1;
            if (keycode[8*i +: 8] == KEY_R)     pressed[PB_R]     = 1'b1;
            if (keycode[8*i +: 8] == KEY_SPACE) pressed[PB_SPACE] = 1'b1;
        end
    end

endmodule : tank_key_decode
`default_nettype wire

// File: rtl/tank_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tank_ctrl_multi
//  Description : Per-player tank controller. Once per frame it decodes up to
//                NKEYS HID keycodes, moves the tank horizontally with edge
//                clamping, adjusts a saturating aim elevation, issues a
//                one-frame shoot pulse from a finite magazine and runs a timed
//                reload. All outputs are registered and reflect the keys
//                sampled on the same frame_clk edge.
//  Config      : TANK_AUTO_RELOAD_EN - when defined, an empty magazine starts
//                a reload on the next frame without the R key.
//  Ports       : frame_clk  in   frame-rate clock, rising edge active
//                Reset      in   asynchronous active-high reset
//                keycode    in   8*NKEYS packed HID slots
//                TankX/Y    out  tank centre position
//                TankS      out  tank half-size (constant SIZE)
//                Direction  out  last effective key: 0 L, 1 R, 2 up, 3 down
//                shoot      out  one-frame fire pulse
//                aim        out  aim elevation
//                ammo       out  rounds remaining
//                reloading  out  high while a reload is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module tank_ctrl_multi
    import tank_pkg::*;
#(
    parameter int NKEYS         = 6,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 639,
    parameter int Y_MIN         = 0,
    parameter int Y_MAX         = 479,
    parameter int X_CENTER      = 320,
    parameter int Y_CENTER      = 240,
    parameter int SIZE          = 4,
    parameter int STEP          = 1,
    parameter int AIM_MAX       = 31,
    parameter int AMMO_MAX      = 5,
    parameter int RELOAD_FRAMES = 60
) (
    input  logic                             frame_clk,
    input  logic                             Reset,
    input  logic [8*NKEYS-1:0]               keycode,
    output logic [9:0]                       TankX,
    output logic [9:0]                       TankY,
    output logic [9:0]                       TankS,
    output logic [1:0]                       Direction,
    output logic                             shoot,
    output logic [9:0]                       aim,
    output logic [$clog2(AMMO_MAX+1)-1:0]    ammo,
    output logic                             reloading
);

    localparam int c_AW = $clog2(AMMO_MAX + 1);
    localparam int c_CW = (RELOAD_FRAMES > 1) ? $clog2(RELOAD_FRAMES) : 1;

    // Clamp limits live in 11-bit signed space so X_MIN+SIZE below zero or
    // a step off the left edge cannot wrap around to a large unsigned value.
    localparam logic signed [10:0] c_X_LO   = 11'(X_MIN + SIZE);
    localparam logic signed [10:0] c_X_HI   = 11'(X_MAX - SIZE);
    localparam logic signed [10:0] c_STEP   = 11'(STEP);
    localparam logic [9:0]         c_AIM_MAX   = 10'(AIM_MAX);
    localparam logic [c_AW-1:0]    c_AMMO_FULL = c_AW'(AMMO_MAX);
    localparam logic [c_CW-1:0]    c_CNT_LAST  = c_CW'(RELOAD_FRAMES - 1);
    // Y never moves; its reset value is kept inside the vertical playfield.
    localparam int c_Y_RST = (Y_CENTER < Y_MIN + SIZE) ? (Y_MIN + SIZE) :
                             (Y_CENTER > Y_MAX - SIZE) ? (Y_MAX - SIZE) : Y_CENTER;

    logic [5:0]        w_pressed;
    logic              w_a, w_d, w_w, w_s, w_r, w_space;
    logic              w_move_l, w_move_r, w_aim_up, w_aim_dn;
    logic              w_fire, w_auto, w_rl_start, w_rl_done;
    logic signed [10:0] w_x_try;
    logic [9:0]        w_aim_next;
    dir_t              w_dir_next;
    rl_state_t         r_state, w_state_next;

    logic [9:0]        r_x, r_y, r_aim;
    dir_t              r_dir;
    logic              r_shoot, r_fire_prev;
    logic [c_AW-1:0]   r_ammo;
    logic [c_CW-1:0]   r_cnt;

    tank_key_decode #(
        .NKEYS   (NKEYS)
    ) u_key_decode (
        .keycode (keycode),
        .pressed (w_pressed)
    );

    assign w_a     = w_pressed[PB_A];
    assign w_d     = w_pressed[PB_D];
    assign w_w     = w_pressed[PB_W];
    assign w_s     = w_pressed[PB_S];
    assign w_r     = w_pressed[PB_R];
    assign w_space = w_pressed[PB_SPACE];

    // Opposing keys cancel each other.
    assign w_move_l = w_a & ~w_d;
    assign w_move_r = w_d & ~w_a;
    assign w_aim_up = w_w & ~w_s;
    assign w_aim_dn = w_s & ~w_w;

`ifdef TANK_AUTO_RELOAD_EN
    assign w_auto = (r_ammo == '0);
`else
    assign w_auto = 1'b0;
`endif

    // Rising edge of SPACE only; holding the key never re-fires.
    assign w_fire     = w_space & ~r_fire_prev & (r_ammo != '0) & (r_state == RL_IDLE);
    // A shot in the same frame wins over R; with an empty magazine no shot
    // is possible, so R starts the reload.
    assign w_rl_start = (r_state == RL_IDLE) & ~w_fire &
                        ((w_r & (r_ammo != c_AMMO_FULL)) | w_auto);
    assign w_rl_done  = (r_state == RL_BUSY) & (r_cnt == c_CNT_LAST);

    // Horizontal move with clamping; also pulls an out-of-range position
    // back inside the playfield.
    always_comb begin
        w_x_try = signed'({1'b0, r_x});
        if (w_move_l) begin
            w_x_try = w_x_try - c_STEP;
        end else if (w_move_r) begin
            w_x_try = w_x_try + c_STEP;
        end
        if (w_x_try < c_X_LO) begin
            w_x_try = c_X_LO;
        end else if (w_x_try > c_X_HI) begin
            w_x_try = c_X_HI;
        end
    end

    always_comb begin
        w_aim_next = r_aim;
        if (w_aim_up && (r_aim < c_AIM_MAX)) begin
            w_aim_next = r_aim + 10'd1;
        end else if (w_aim_dn && (r_aim != '0)) begin
            w_aim_next = r_aim - 10'd1;
        end
    end

    // Direction follows the resolved key, even when the move or aim step is
    // blocked by an edge or saturation; movement has priority over aim.
    always_comb begin
        w_dir_next = r_dir;
        if (w_move_l) begin
            w_dir_next = DIR_LEFT;
        end else if (w_move_r) begin
            w_dir_next = DIR_RIGHT;
        end else if (w_aim_up) begin
            w_dir_next = DIR_UP;
        end else if (w_aim_dn) begin
            w_dir_next = DIR_DOWN;
        end
    end

    // Reload state machine
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state <= RL_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RL_IDLE: if (w_rl_start) w_state_next = RL_BUSY;
            RL_BUSY: if (w_rl_done)  w_state_next = RL_IDLE;
            default:                 w_state_next = RL_IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_x         <= 10'(X_CENTER);
            r_y         <= 10'(c_Y_RST);
            r_aim       <= '0;
            r_dir       <= DIR_RIGHT;
            r_shoot     <= 1'b0;
            r_fire_prev <= 1'b0;
            r_ammo      <= c_AMMO_FULL;
            r_cnt       <= '0;
        end else begin
            r_x         <= w_x_try[9:0];
            r_aim       <= w_aim_next;
            r_dir       <= w_dir_next;
            r_shoot     <= w_fire;
            r_fire_prev <= w_space;
            if (w_fire) begin
                r_ammo <= r_ammo - c_AW'(1);
            end else if (w_rl_done) begin
                r_ammo <= c_AMMO_FULL;
            end
            if (w_rl_start || w_rl_done) begin
                r_cnt <= '0;
            end else if (r_state == RL_BUSY) begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

    assign TankX     = r_x;
    assign TankY     = r_y;
    assign TankS     = 10'(SIZE);
    assign Direction = r_dir;
    assign shoot     = r_shoot;
    assign aim       = r_aim;
    assign ammo      = r_ammo;
    assign reloading = (r_state == RL_BUSY);

endmodule : tank_ctrl_multi
`default_nettype wire

// File: tb/tb_tank_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tank_ctrl_multi
//  Description : Self-checking bench for tank_ctrl_multi with default
//                parameters. A frame-level behavioural model tracks the
//                expected outputs; directed steps cover movement, clamping,
//                aim saturation, firing, reload and async reset, followed by
//                random keycode frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tank_ctrl_multi;

    localparam int NKEYS = 6, X_MIN = 0, X_MAX = 639, Y_MIN = 0, Y_MAX = 479;
    localparam int X_CENTER = 320, Y_CENTER = 240, SIZE = 4, STEP = 1;
    localparam int AIM_MAX = 31, AMMO_MAX = 5, RELOAD_FRAMES = 60;
`ifdef TANK_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic                  frame_clk = 1'b0;
    logic                  Reset;
    logic [8*NKEYS-1:0]    keycode;
    logic [9:0]            TankX, TankY, TankS, aim;
    logic [1:0]            Direction;
    logic                  shoot, reloading;
    logic [2:0]            ammo;

    tank_ctrl_multi #(
        .NKEYS(NKEYS), .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
        .X_CENTER(X_CENTER), .Y_CENTER(Y_CENTER), .SIZE(SIZE), .STEP(STEP),
        .AIM_MAX(AIM_MAX), .AMMO_MAX(AMMO_MAX), .RELOAD_FRAMES(RELOAD_FRAMES)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .TankX     (TankX),
        .TankY     (TankY),
        .TankS     (TankS),
        .Direction (Direction),
        .shoot     (shoot),
        .aim       (aim),
        .ammo      (ammo),
        .reloading (reloading)
    );

    always #5 frame_clk = ~frame_clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int m_x, m_aim, m_dir, m_ammo, m_left;
    bit m_rl, m_prev, m_shoot;
    int shoot_tally, rl_tally;

    function automatic bit has(input logic [8*NKEYS-1:0] kc, input logic [7:0] code);
        bit hit = 1'b0;
        for (int i = 0; i < NKEYS; i++) if (kc[8*i +: 8] == code) hit = 1'b1;
        return hit;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = X_CENTER; m_aim = 0; m_dir = 1; m_ammo = AMMO_MAX;
        m_left = 0; m_rl = 1'b0; m_prev = 1'b0; m_shoot = 1'b0;
    endtask

    task automatic model_frame(input logic [8*NKEYS-1:0] kc);
        bit a, d, w, s, r, sp, fire;
        a  = has(kc, 8'h04); d = has(kc, 8'h07);
        w  = has(kc, 8'h1A); s = has(kc, 8'h16);
        r  = has(kc, 8'h15); sp = has(kc, 8'h2C);
        fire = sp && !m_prev && (m_ammo > 0) && !m_rl;
        if (a != d) begin
            m_x = a ? m_x - STEP : m_x + STEP;
            if (m_x < X_MIN + SIZE) m_x = X_MIN + SIZE;
            if (m_x > X_MAX - SIZE) m_x = X_MAX - SIZE;
            m_dir = a ? 0 : 1;
        end else if (w != s) begin
            m_dir = w ? 2 : 3;
        end
        if (w && !s && m_aim < AIM_MAX) m_aim++;
        if (s && !w && m_aim > 0) m_aim--;
        if (m_rl) begin
            m_left--;
            if (m_left == 0) begin m_rl = 1'b0; m_ammo = AMMO_MAX; end
        end else if (fire) begin
            m_ammo--;
        end else if ((r && m_ammo < AMMO_MAX) || (AUTO && m_ammo == 0)) begin
            m_rl = 1'b1; m_left = RELOAD_FRAMES;
        end
        m_shoot = fire;
        m_prev  = sp;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".TankX"},     TankX,     m_x);
        chk({tag, ".TankY"},     TankY,     Y_CENTER);
        chk({tag, ".TankS"},     TankS,     SIZE);
        chk({tag, ".Direction"}, Direction, m_dir);
        chk({tag, ".shoot"},     shoot,     m_shoot);
        chk({tag, ".aim"},       aim,       m_aim);
        chk({tag, ".ammo"},      ammo,      m_ammo);
        chk({tag, ".reloading"}, reloading, m_rl);
    endtask

    task automatic frame(input logic [8*NKEYS-1:0] kc, input string tag);
        keycode = kc;
        @(posedge frame_clk);
        model_frame(kc);
        #1;
        check_all(tag);
        shoot_tally += int'(shoot);
        rl_tally    += int'(reloading);
    endtask

    localparam logic [47:0] K0  = 48'h0;
    localparam logic [47:0] KD3 = 48'h07 << 24;
    localparam logic [47:0] KAD = 48'h0704;
    localparam logic [47:0] KA  = 48'h04 << 40;
    localparam logic [47:0] KW  = 48'h1A;
    localparam logic [47:0] KWS = 48'h161A00;
    localparam logic [47:0] KSP = 48'h2C << 16;
    localparam logic [47:0] KR  = 48'h15 << 8;

    initial begin
        int x_saved;
        logic [7:0] pool [8];
        logic [47:0] kc;
        pool[0] = 8'h04; pool[1] = 8'h07; pool[2] = 8'h1A; pool[3] = 8'h16;
        pool[4] = 8'h15; pool[5] = 8'h2C; pool[6] = 8'h00; pool[7] = 8'h00;
        shoot_tally = 0; rl_tally = 0;

        // Reset state, checked while reset is still asserted
        Reset = 1'b1; keycode = '0;
        model_reset();
        #12;
        check_all("reset");
        Reset = 1'b0;

        // Hold D in slot 3: rise 1/frame, stop at X_MAX-SIZE
        frame(KD3, "d_first");
        chk("d_step1", TankX, X_CENTER + 1);
        for (int i = 1; i < 400; i++) frame(KD3, "d_hold");
        chk("d_edge", TankX, 635);
        chk("d_dir", Direction, 1);

        // A and D together: no move
        x_saved = m_x;
        for (int i = 0; i < 10; i++) frame(KAD, "a_and_d");
        chk("ad_hold", TankX, x_saved);
        // A alone to the left edge, then keep pushing
        for (int i = 0; i < 700; i++) frame(KA, "a_hold");
        chk("a_edge", TankX, 4);
        chk("a_dir", Direction, 0);

        // Aim saturation, then W+S holds
        for (int i = 0; i < 40; i++) frame(KW, "w_hold");
        chk("aim_sat", aim, 31);
        for (int i = 0; i < 5; i++) frame(KWS, "w_and_s");
        chk("aim_ws", aim, 31);
        for (int i = 0; i < 35; i++) frame(48'h16, "s_hold");
        chk("aim_floor", aim, 0);

        // SPACE held: one pulse only
        shoot_tally = 0;
        for (int i = 0; i < 10; i++) frame(KSP, "sp_hold");
        chk("sp_pulses", shoot_tally, 1);
        chk("sp_ammo", ammo, 4);
        frame(K0, "sp_rel");
        // Four more taps empty the magazine
        for (int i = 0; i < 4; i++) begin
            frame(KSP, "tap");
            frame(K0, "tap_gap");
        end
        chk("taps_pulses", shoot_tally, 5);
        chk("taps_ammo", ammo, 0);
`ifdef TANK_AUTO_RELOAD_EN
        chk("auto_reload_rise", reloading, 1);
`endif
        frame(KSP, "tap6");
        chk("tap6_pulses", shoot_tally, 5);
        chk("tap6_ammo", ammo, 0);
        frame(KR, "r_empty");
        for (int i = 0; i < 62; i++) frame(K0, "refill");
        chk("refill_ammo", ammo, 5);

        // ammo=3, R: reload for 60 frames, SPACE ignored meanwhile
        for (int i = 0; i < 2; i++) begin
            frame(KSP, "tap5");
            frame(K0, "tap5_gap");
        end
        chk("pre_r_ammo", ammo, 3);
        shoot_tally = 0; rl_tally = 0;
        frame(KR, "r_press");
        for (int i = 0; i < 59; i++) frame((i % 2 == 0) ? KSP : KR, "reload_busy");
        chk("reload_frames", rl_tally, 60);
        chk("reload_noshoot", shoot_tally, 0);
        frame(K0, "reload_end");
        chk("reload_ammo", ammo, 5);
        chk("reload_done", reloading, 0);
        frame(KR, "r_full");
        chk("r_full_ignored", reloading, 0);

        // Async reset at reload frame 30
        for (int i = 0; i < 2; i++) begin
            frame(KSP, "tap6b");
            frame(K0, "tap6b_gap");
        end
        frame(KR, "r_press2");
        for (int i = 0; i < 29; i++) frame(K0, "reload30");
        chk("mid_reload", reloading, 1);
        #2 Reset = 1'b1;
        model_reset();
        #1;
        chk("async_rl", reloading, 0);
        chk("async_ammo", ammo, 5);
        check_all("async");
        #2 Reset = 1'b0;

        // Random frames
        for (int n = 0; n < 400; n++) begin
            kc = '0;
            for (int i = 0; i < NKEYS; i++) begin
                if ($urandom_range(0, 3) == 0) kc[8*i +: 8] = 8'($urandom);
                else kc[8*i +: 8] = pool[$urandom_range(0, 7)];
            end
            frame(kc, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_tank_ctrl_multi
`default_nettype wire
